// File: rtl/seq_alu_if.sv
// Issue/result bundle between the execute stage and the multi-cycle ALU.
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             zero;
   logic             div_by_zero;
   logic             busy;
   logic             done;

   modport master (
      output start, op, a, b,
      input  result_lo, result_hi, zero, div_by_zero, busy, done
   );

   modport slave (
      input  start, op, a, b,
      output result_lo, result_hi, zero, div_by_zero, busy, done
   );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add MULU and restoring DIVU producing a HI/LO pair.
//
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | one MULU/DIVU iteration per cycle, busy=1, counter counts down
//  DONE  | results valid, done=1, may accept a back-to-back start
module seq_alu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input logic       clk,
   input logic       rst_n,
   seq_alu_if.slave  bus
);
   localparam int CNT_W = SHAMT_W + 1;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   localparam logic [3:0] OP_MULU = 4'b1100;
   localparam logic [3:0] OP_DIVU = 4'b1101;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic               accept;
   logic               is_multi;
   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   res_lo, res_hi;
   logic               dbz;
   logic [WIDTH-1:0]   alu_lo;
   logic [SHAMT_W-1:0] shamt;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_nxt;
   logic [WIDTH:0]     trial;
   logic               fits;
   logic [WIDTH:0]     rem_nxt;
   logic [WIDTH-1:0]   quo_nxt;

   assign shamt    = bus.b[SHAMT_W-1:0];
   assign is_multi = (bus.op == OP_MULU) || (bus.op == OP_DIVU);

   always_comb begin
      alu_lo = '0;
      case (bus.op)
         OP_AND:  alu_lo = bus.a & bus.b;
         OP_OR:   alu_lo = bus.a | bus.b;
         OP_ADD:  alu_lo = bus.a + bus.b;
         OP_XOR:  alu_lo = bus.a ^ bus.b;
         OP_NOR:  alu_lo = ~(bus.a | bus.b);
         OP_SUB:  alu_lo = bus.a - bus.b;
         OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         OP_SLL:  alu_lo = bus.a << shamt;
         OP_SRL:  alu_lo = bus.a >> shamt;
         OP_SRA:  alu_lo = $signed(bus.a) >>> shamt;
         default: alu_lo = '0;
      endcase
   end

   // Multiplier sits in the low half of prod and shifts out LSB-first
   assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
   assign prod_nxt = {mul_sum, prod[WIDTH-1:1]};

   // Dividend shifts out of quo MSB-first while quotient bits shift in
   assign trial   = {rem[WIDTH-1:0], quo[WIDTH-1]};
   assign fits    = trial >= {1'b0, opnd};
   assign rem_nxt = fits ? (trial - {1'b0, opnd}) : trial;
   assign quo_nxt = {quo[WIDTH-2:0], fits};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: if (bus.start) accept = 1'b1;
         RUN:  if (cnt == CNT_W'(1)) state_nxt = DONE;
         DONE: if (bus.start) accept = 1'b1;
                else          state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (accept) state_nxt = is_multi ? RUN : DONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         is_div <= 1'b0;
         opnd   <= '0;
         prod   <= '0;
         rem    <= '0;
         quo    <= '0;
         res_lo <= '0;
         res_hi <= '0;
         dbz    <= 1'b0;
      end else if (accept) begin
         if (is_multi) begin
            is_div <= (bus.op == OP_DIVU);
            opnd   <= (bus.op == OP_DIVU) ? bus.b : bus.a;
            prod   <= {{WIDTH{1'b0}}, bus.b};
            rem    <= '0;
            quo    <= bus.a;
            cnt    <= CNT_W'(WIDTH);
         end else begin
            res_lo <= alu_lo;
            res_hi <= '0;
            dbz    <= 1'b0;
         end
      end else if (state == RUN) begin
         cnt <= cnt - CNT_W'(1);
         if (is_div) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
         end else begin
            prod <= prod_nxt;
         end
         if (cnt == CNT_W'(1)) begin
            res_lo <= is_div ? quo_nxt : prod_nxt[WIDTH-1:0];
            res_hi <= is_div ? rem_nxt[WIDTH-1:0] : prod_nxt[2*WIDTH-1:WIDTH];
            dbz    <= is_div && (opnd == '0);
         end
      end
   end

   assign bus.result_lo   = res_lo;
   assign bus.result_hi   = res_hi;
   assign bus.zero        = (res_lo == '0);
   assign bus.div_by_zero = dbz;
   assign bus.busy        = (state == RUN);
   assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model.
module tb_seq_alu;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(32)) b32 ();
   seq_alu_if #(.WIDTH(8))  b8  ();

   seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [3:0] o, input logic [63:0] xi, input logic [63:0] yi,
                                 input int w, output logic [63:0] hi, output logic [63:0] lo);
      logic [63:0] m, x, y, p;
      longint sx, sy;
      int sh;
      m  = (64'd1 << w) - 64'd1;
      x  = xi & m;
      y  = yi & m;
      sx = x[w-1] ? longint'(x) - longint'(64'd1 << w) : longint'(x);
      sy = y[w-1] ? longint'(y) - longint'(64'd1 << w) : longint'(y);
      sh = int'(y % 64'(w));
      hi = 0;
      case (o)
         4'd0:  lo = x & y;
         4'd1:  lo = x | y;
         4'd2:  lo = (x + y) & m;
         4'd3:  lo = x ^ y;
         4'd4:  lo = ~(x | y) & m;
         4'd6:  lo = (x - y) & m;
         4'd7:  lo = (sx < sy) ? 64'd1 : 64'd0;
         4'd8:  lo = (x < y) ? 64'd1 : 64'd0;
         4'd9:  lo = (x << sh) & m;
         4'd10: lo = x >> sh;
         4'd11: lo = 64'(sx >>> sh) & m;
         4'd12: begin p = x * y; lo = p & m; hi = p >> w; end
         4'd13: begin
            if (y == 0) begin lo = m; hi = x; end
            else begin lo = x / y; hi = x % y; end
         end
         default: lo = 0;
      endcase
   endfunction

   task automatic set_in(input int w, input logic s, input logic [3:0] o,
                         input logic [63:0] x, input logic [63:0] y);
      if (w == 8) begin b8.start = s; b8.op = o; b8.a = x[7:0]; b8.b = y[7:0]; end
      else begin b32.start = s; b32.op = o; b32.a = x[31:0]; b32.b = y[31:0]; end
   endtask

   task automatic clr_start(input int w);
      if (w == 8) b8.start = 1'b0;
      else        b32.start = 1'b0;
   endtask

   task automatic get_out(input int w, output logic [63:0] lo, output logic [63:0] hi,
                          output logic z, output logic dz, output logic bs, output logic dn);
      if (w == 8) begin
         lo = 64'(b8.result_lo); hi = 64'(b8.result_hi);
         z = b8.zero; dz = b8.div_by_zero; bs = b8.busy; dn = b8.done;
      end else begin
         lo = 64'(b32.result_lo); hi = 64'(b32.result_hi);
         z = b32.zero; dz = b32.div_by_zero; bs = b32.busy; dn = b32.done;
      end
   endtask

   task automatic check_reset_outs(input int w, input string tag);
      logic [63:0] lo, hi;
      logic z, dz, bs, dn;
      get_out(w, lo, hi, z, dz, bs, dn);
      check({tag, "_lo"}, lo, 0);
      check({tag, "_hi"}, hi, 0);
      check({tag, "_zero"}, 64'(z), 1);
      check({tag, "_dbz"}, 64'(dz), 0);
      check({tag, "_busy"}, 64'(bs), 0);
      check({tag, "_done"}, 64'(dn), 0);
   endtask

   // Called just after a rising edge; returns in the cycle where done is high.
   task automatic run_op(input int w, input string tag, input logic [3:0] o,
                         input logic [63:0] x, input logic [63:0] y, input int glitch);
      logic [63:0] eh, el, lo, hi;
      logic z, dz, bs, dn;
      logic multi;
      int lat;
      model(o, x, y, w, eh, el);
      multi = (o == 4'd12) || (o == 4'd13);
      set_in(w, 1'b1, o, x, y);
      @(posedge clk); #1;
      clr_start(w);
      lat = 1;
      get_out(w, lo, hi, z, dz, bs, dn);
      while (!dn && lat < w + 8) begin
         check({tag, "_busy_run"}, 64'(bs), 64'(multi));
         if (lat == glitch) set_in(w, 1'b1, 4'd2, 64'($urandom), 64'($urandom));
         @(posedge clk); #1;
         clr_start(w);
         lat++;
         get_out(w, lo, hi, z, dz, bs, dn);
      end
      check({tag, "_latency"}, 64'(lat), multi ? 64'(w + 1) : 64'd1);
      check({tag, "_lo"}, lo, el);
      check({tag, "_hi"}, hi, eh);
      check({tag, "_zero"}, 64'(z), 64'(el == 0));
      check({tag, "_dbz"}, 64'(dz), 64'((o == 4'd13) && ((y & ((64'd1 << w) - 1)) == 0)));
      check({tag, "_busy_done"}, 64'(bs), 0);
   endtask

   task automatic idle(input int w, input int n);
      logic [63:0] lo, hi;
      logic z, dz, bs, dn;
      repeat (n) begin @(posedge clk); #1; end
      get_out(w, lo, hi, z, dz, bs, dn);
      check("idle_done", 64'(dn), 0);
   endtask

   task automatic random_ops(input int w, input int n);
      logic [3:0] o;
      logic [63:0] x, y;
      int g;
      for (int i = 0; i < n; i++) begin
         o = 4'($urandom_range(0, 15));
         x = 64'($urandom);
         y = ($urandom_range(0, 5) == 0) ? 64'($urandom_range(0, 3)) : 64'($urandom);
         g = ($urandom_range(0, 2) == 0) ? $urandom_range(1, w - 1) : -1;
         run_op(w, "rand", o, x, y, g);
         if ($urandom_range(0, 3) == 0) idle(w, $urandom_range(1, 3));
      end
   endtask

   initial begin
      logic [63:0] r;
      logic [63:0] lo, hi;
      logic z, dz, bs, dn;
      rst_n = 1'b0;
      set_in(32, 1'b0, 4'd0, 0, 0);
      set_in(8, 1'b0, 4'd0, 0, 0);
      #3;
      check_reset_outs(32, "rst32");
      check_reset_outs(8, "rst8");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(32, "add_wrap", 4'd2, 64'hFFFF_FFFF, 64'd1, -1);
      run_op(32, "slt",  4'd7, 64'hFFFF_FFFF, 64'd1, -1);
      run_op(32, "sltu", 4'd8, 64'hFFFF_FFFF, 64'd1, -1);
      idle(32, 2);
      run_op(32, "sra", 4'd11, 64'h8000_0000, 64'd4, -1);
      run_op(32, "srl", 4'd10, 64'h8000_0000, 64'd4, -1);
      r = 64'($urandom);
      run_op(32, "sll_mask", 4'd9, r, 64'h21, -1);
      run_op(32, "mulu_glitch", 4'd12, 64'hFFFF_FFFF, 64'd2, 10);
      run_op(32, "add_b2b", 4'd2, 64'd5, 64'd6, -1);
      run_op(32, "divu", 4'd13, 64'd100, 64'd7, -1);
      run_op(32, "divu_zero", 4'd13, 64'd5, 64'd0, -1);
      idle(32, 1);
      run_op(32, "undef_op", 4'd5, 64'h1234, 64'h5678, -1);
      run_op(32, "divu_zero2", 4'd13, 64'hDEAD_BEEF, 64'd0, -1);

      // Reset in the middle of a DIVU, with non-reset results still held
      set_in(32, 1'b1, 4'd13, 64'd1000, 64'd3);
      @(posedge clk); #1;
      clr_start(32);
      repeat (14) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check_reset_outs(32, "midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         get_out(32, lo, hi, z, dz, bs, dn);
         check("post_rst_done", 64'(dn), 0);
      end
      run_op(32, "post_rst_divu", 4'd13, 64'd1000, 64'd3, -1);

      random_ops(32, 40);

      run_op(8, "mulu8", 4'd12, 64'hFF, 64'hFF, 3);
      run_op(8, "divu8", 4'd13, 64'd200, 64'd7, -1);
      run_op(8, "divu8_zero", 4'd13, 64'h5A, 64'd0, -1);
      run_op(8, "sra8", 4'd11, 64'h80, 64'd4, -1);
      run_op(8, "sll8_mask", 4'd9, 64'h81, 64'h09, -1);
      random_ops(8, 40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
